// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: ALU select codes,
// ALUop codes, funct7 patterns, FSM state encoding and a funct3 helper.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [1:0] OP_LS = 2'b00;
  localparam logic [1:0] OP_BR = 2'b01;
  localparam logic [1:0] OP_R  = 2'b10;
  localparam logic [1:0] OP_I  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MD_RUN,
    ST_MD_DONE
  } state_t;

  function automatic logic [3:0] base_sel(
    input logic [2:0] f3
  );
    logic [3:0] s;
    unique case (f3)
      3'b000:  s = ALU_ADD;
      3'b001:  s = ALU_SLL;
      3'b010:  s = ALU_SLT;
      3'b011:  s = ALU_SLTU;
      3'b100:  s = ALU_XOR;
      3'b101:  s = ALU_SRL;
      3'b110:  s = ALU_OR;
      default: s = ALU_AND;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle of the ALU control sequencer.
// master = control unit side, slave = alu_ctrl_seq.
interface alu_ctrl_seq_if;

  logic       flush_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [1:0] alu_op_i;
  logic [2:0] funct3_i;
  logic [6:0] funct7_i;
  logic       out_valid_o;
  logic [3:0] alu_sel_o;
  logic       md_sel_o;
  logic [2:0] md_op_o;
  logic       md_start_o;
  logic       md_busy_o;
  logic       illegal_o;

  modport master (
    output flush_i, in_valid_i,
    output alu_op_i, funct3_i, funct7_i,
    input  in_ready_o, out_valid_o,
    input  alu_sel_o, md_sel_o, md_op_o,
    input  md_start_o, md_busy_o, illegal_o
  );

  modport slave (
    input  flush_i, in_valid_i,
    input  alu_op_i, funct3_i, funct7_i,
    output in_ready_o, out_valid_o,
    output alu_sel_o, md_sel_o, md_op_o,
    output md_start_o, md_busy_o, illegal_o
  );

endinterface

// File: rtl/alu_sel_decode.sv
// Combinational alu_op/funct3/funct7 -> {alu_sel, is_md, illegal}.
// is_md exists only when ALU_CTRL_M_EXT_EN is defined.
module alu_sel_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_sel,
`ifdef ALU_CTRL_M_EXT_EN
  output logic       is_md,
`endif
  output logic       illegal
);

  always_comb begin
    alu_sel = ALU_ADD;
    illegal = 1'b0;
`ifdef ALU_CTRL_M_EXT_EN
    is_md   = 1'b0;
`endif
    unique case (alu_op)
      OP_LS: alu_sel = ALU_ADD;
      OP_BR: alu_sel = ALU_SUB;
      OP_R: begin
        unique case (1'b1)
          (funct7 == F7_BASE):
            alu_sel = base_sel(funct3);
          (funct7 == F7_ALT): begin
            if (funct3 == 3'b000)
              alu_sel = ALU_SUB;
            else if (funct3 == 3'b101)
              alu_sel = ALU_SRA;
            else
              illegal = 1'b1;
          end
`ifdef ALU_CTRL_M_EXT_EN
          (funct7 == F7_MULDIV):
            is_md = 1'b1;
`endif
          default: illegal = 1'b1;
        endcase
      end
      default: begin
        // I-type: no SUBI, funct7 only matters for shifts
        unique case (1'b1)
          (funct3 == 3'b001): begin
            if (funct7 == F7_BASE)
              alu_sel = ALU_SLL;
            else
              illegal = 1'b1;
          end
          (funct3 == 3'b101): begin
            if (funct7 == F7_BASE)
              alu_sel = ALU_SRL;
            else if (funct7 == F7_ALT)
              alu_sel = ALU_SRA;
            else
              illegal = 1'b1;
          end
          default: alu_sel = base_sel(funct3);
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decode plus RV32M multi-cycle sequencing.
// Ports: clk, rst (async high), bus (alu_ctrl_seq_if.slave).
// Macro ALU_CTRL_M_EXT_EN enables MD decode and MD_RUN/MD_DONE states.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33
) (
  input logic          clk,
  input logic          rst,
  alu_ctrl_seq_if.slave bus
);

  logic [3:0] dec_sel;
  logic       dec_ill;
  logic       in_ready;
  logic       accept;
  logic [3:0] alu_sel_q;
  logic       illegal_q;
  logic [2:0] md_op_q;
  logic       out_valid_q;

  assign accept = in_ready & bus.in_valid_i
                & ~bus.flush_i;

`ifdef ALU_CTRL_M_EXT_EN
  logic dec_md;
`endif

  alu_sel_decode u_dec (
    .alu_op  (bus.alu_op_i),
    .funct3  (bus.funct3_i),
    .funct7  (bus.funct7_i),
    .alu_sel (dec_sel),
`ifdef ALU_CTRL_M_EXT_EN
    .is_md   (dec_md),
`endif
    .illegal (dec_ill)
  );

  // Decode results only change on accept and hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_sel_q <= ALU_ADD;
      illegal_q <= 1'b0;
      md_op_q   <= 3'b000;
    end else if (accept) begin
      alu_sel_q <= dec_sel;
      illegal_q <= dec_ill;
      md_op_q   <= bus.funct3_i;
    end
  end

`ifdef ALU_CTRL_M_EXT_EN
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES)
                      ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] MUL_LD =
    CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD =
    CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             md_sel_q;
  logic             md_start_q;
  logic             md_busy_q;

  assign in_ready = (state == ST_IDLE);

  // Counter loads N-1 so MD_RUN spans exactly N cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      md_sel_q    <= 1'b0;
      md_start_q  <= 1'b0;
      md_busy_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      md_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            md_sel_q <= dec_md;
            if (dec_md) begin
              cnt        <= bus.funct3_i[2]
                          ? DIV_LD : MUL_LD;
              md_start_q <= 1'b1;
              md_busy_q  <= 1'b1;
              state      <= ST_MD_RUN;
            end else begin
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_MD_RUN: begin
          if (bus.flush_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            md_busy_q <= 1'b0;
          end else if (cnt == '0) begin
            state       <= ST_MD_DONE;
            md_busy_q   <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.md_sel_o   = md_sel_q;
  assign bus.md_start_o = md_start_q;
  assign bus.md_busy_o  = md_busy_q;
`else
  assign in_ready = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_valid_q <= 1'b0;
    else
      out_valid_q <= accept;
  end

  assign bus.md_sel_o   = 1'b0;
  assign bus.md_start_o = 1'b0;
  assign bus.md_busy_o  = 1'b0;
`endif

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.alu_sel_o   = alu_sel_q;
  assign bus.illegal_o   = illegal_q;
  assign bus.md_op_o     = md_op_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: expected decode pushed on accept,
// popped and compared on every out_valid_o pulse.
module tb_alu_ctrl_seq;
  import alu_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] sel;
    logic       ill;
    logic       md;
    logic [2:0] op;
  } exp_t;

`ifdef ALU_CTRL_M_EXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_ctrl_seq_if bus ();

  alu_ctrl_seq #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (33)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  bit   start_seen = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_sel(
    input logic [2:0] f3
  );
    case (f3)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b1000;
      3'd2:    return 4'b1101;
      3'd3:    return 4'b1111;
      3'd4:    return 4'b0111;
      3'd5:    return 4'b1001;
      3'd6:    return 4'b0100;
      default: return 4'b0101;
    endcase
  endfunction

  function automatic exp_t model(
    input logic [1:0] op,
    input logic [2:0] f3,
    input logic [6:0] f7
  );
    exp_t e;
    e.sel = 4'b0000;
    e.ill = 1'b0;
    e.md  = 1'b0;
    e.op  = f3;
    case (op)
      2'b01: e.sel = 4'b0001;
      2'b10: begin
        if (f7 == 7'h00)
          e.sel = ref_sel(f3);
        else if (f7 == 7'h20 && f3 == 3'd0)
          e.sel = 4'b0001;
        else if (f7 == 7'h20 && f3 == 3'd5)
          e.sel = 4'b1011;
        else if (f7 == 7'h01 && MEXT)
          e.md = 1'b1;
        else
          e.ill = 1'b1;
      end
      2'b11: begin
        if (f3 == 3'd1) begin
          if (f7 == 7'h00) e.sel = 4'b1000;
          else             e.ill = 1'b1;
        end else if (f3 == 3'd5) begin
          if (f7 == 7'h00)      e.sel = 4'b1001;
          else if (f7 == 7'h20) e.sel = 4'b1011;
          else                  e.ill = 1'b1;
        end else begin
          e.sel = ref_sel(f3);
        end
      end
      default: e.sel = 4'b0000;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (bus.md_start_o) start_seen = 1'b1;
      if (bus.out_valid_o) begin
        if (sbq.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("alu_sel", bus.alu_sel_o, e.sel);
          chk("illegal", bus.illegal_o, e.ill);
          chk("md_sel", bus.md_sel_o, e.md);
          if (e.md)
            chk("md_op", bus.md_op_o, e.op);
        end
      end
    end
  end

  // Call at a negedge; returns at a negedge
  task automatic send(input logic [1:0] op,
                      input logic [2:0] f3,
                      input logic [6:0] f7);
    exp_t e;
    bit   rdy;
    bit   done;
    int   k;
    e    = model(op, f3, f7);
    done = 1'b0;
    bus.alu_op_i   = op;
    bus.funct3_i   = f3;
    bus.funct7_i   = f7;
    bus.in_valid_i = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      rdy = bus.in_ready_o;
      @(posedge clk);
      if (rdy) begin
        sbq.push_back(e);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (done) @(negedge clk);
    bus.in_valid_i = 1'b0;
    if (!done) begin
      chk("accept_timeout", 0, 1);
    end else if (!e.md) begin
      chk("lat1_valid", bus.out_valid_o, 1);
    end else begin
      k = 0;
      while (!bus.out_valid_o && k < 60) begin
        @(negedge clk);
        k++;
      end
      chk("md_done_timeout", bus.out_valid_o, 1);
    end
  endtask

  task automatic accept_md(input logic [2:0] f3,
                           input bit push);
    bus.alu_op_i   = OP_R;
    bus.funct3_i   = f3;
    bus.funct7_i   = F7_MULDIV;
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    if (push) sbq.push_back(model(OP_R, f3, F7_MULDIV));
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] f7;
    rst            = 1'b1;
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.alu_op_i   = 2'b00;
    bus.funct3_i   = 3'b000;
    bus.funct7_i   = 7'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.in_ready_o, 1);
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_sel", bus.alu_sel_o, 0);
    chk("rst_ill", bus.illegal_o, 0);
    chk("rst_busy", bus.md_busy_o, 0);
    chk("rst_start", bus.md_start_o, 0);
    chk("rst_mdsel", bus.md_sel_o, 0);
    rst = 1'b0;
    @(negedge clk);

    send(OP_R, 3'd0, F7_ALT);
    send(OP_R, 3'd5, F7_BASE);
    send(OP_I, 3'd0, F7_ALT);
    send(OP_I, 3'd1, F7_ALT);
    send(OP_I, 3'd5, F7_ALT);
    send(OP_LS, 3'd3, 7'h55);
    send(OP_BR, 3'd7, 7'h7f);
    send(OP_R, 3'd7, F7_BASE);
    send(OP_R, 3'd2, F7_ALT);
    send(OP_R, 3'd0, 7'h10);
    send(OP_I, 3'd6, 7'h7f);
    send(OP_I, 3'd5, 7'h10);
    send(OP_I, 3'd1, F7_BASE);
    send(OP_R, 3'd3, F7_BASE);
    send(OP_I, 3'd2, F7_ALT);

    bus.alu_op_i   = OP_BR;
    bus.in_valid_i = 1'b1;
    bus.flush_i    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("flush_idle_drop", bus.out_valid_o, 0);
    chk("hold_sel", bus.alu_sel_o, 4'b1101);
    bus.in_valid_i = 1'b0;
    bus.flush_i    = 1'b0;

    bus.alu_op_i   = OP_BR;
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid_o, 0);
    chk("arst_sel", bus.alu_sel_o, 0);
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef ALU_CTRL_M_EXT_EN
    accept_md(3'd0, 1'b1);
    chk("mul_c1_start", bus.md_start_o, 1);
    chk("mul_c1_busy", bus.md_busy_o, 1);
    chk("mul_c1_ready", bus.in_ready_o, 0);
    bus.alu_op_i   = OP_BR;
    bus.funct3_i   = 3'd0;
    bus.funct7_i   = 7'h00;
    bus.in_valid_i = 1'b1;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("mul_c%0d_start", c),
          bus.md_start_o, 0);
      chk($sformatf("mul_c%0d_busy", c),
          bus.md_busy_o, 32'(c <= 4));
      chk($sformatf("mul_c%0d_valid", c),
          bus.out_valid_o, 32'(c == 5));
      chk($sformatf("mul_c%0d_ready", c),
          bus.in_ready_o, 0);
    end
    send(OP_BR, 3'd0, 7'h00);

    accept_md(3'd5, 1'b1);
    for (int c = 1; c <= 34; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("divu_c%0d_valid", c),
          bus.out_valid_o, 32'(c == 34));
    end
    @(negedge clk);

    accept_md(3'd5, 1'b0);
    repeat (9) @(negedge clk);
    chk("flush_c10_busy", bus.md_busy_o, 1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush_c11_ready", bus.in_ready_o, 1);
    chk("flush_c11_busy", bus.md_busy_o, 0);
    chk("flush_c11_valid", bus.out_valid_o, 0);
    repeat (30) @(negedge clk);

    accept_md(3'd1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmd_ready", bus.in_ready_o, 1);
    chk("rstmd_busy", bus.md_busy_o, 0);
    chk("rstmd_valid", bus.out_valid_o, 0);
    chk("rstmd_start", bus.md_start_o, 0);
    rst = 1'b0;
    @(negedge clk);
`else
    send(OP_R, 3'd0, F7_MULDIV);
    send(OP_R, 3'd4, F7_MULDIV);
`endif

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       f7 = F7_BASE;
        1:       f7 = F7_ALT;
        2:       f7 = F7_MULDIV;
        default: f7 = 7'($urandom);
      endcase
      send(2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), f7);
    end

    repeat (2) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
`ifndef ALU_CTRL_M_EXT_EN
    chk("md_start_never", start_seen, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
